vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised, runtime-reconfigurable raster timing generator for the display path. It produces registered hsync, vsync, data-enable, relative pixel coordinates and frame/line strobes from a single pixel clock. Horizontal and vertical timing come from shadowed configuration registers that apply only at a frame boundary, so one bitstream can drive 1080p, 720p or VGA-class modes without tearing. It sits between the pixel-clock domain reset/clock logic and the pixel source or framebuffer reader.

## Interface
- CW, 12: counter/config width; every total must be < 2^CW.
- H_ACTIVE, 1920: reset value of the active pixels per line.
- H_FP, 88: reset value of the horizontal front porch.
- H_SYNC, 44: reset value of the horizontal sync width.
- H_BP, 148: reset value of the horizontal back porch.
- V_ACTIVE, 1080 / V_FP, 4 / V_SYNC, 5 / V_BP, 36: vertical counterparts of the above, in lines.
- HS_POL, 1 / VS_POL, 1: asserted sync level (1 = active-high).
- clk  in  1  pixel clock.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  advance enable; when low, counters freeze.
- cfg_we  in  1  staging-register write strobe.
- cfg_addr  in  3  staging register select: 0 H_ACTIVE, 1 H_FP, 2 H_SYNC, 3 H_BP, 4 V_ACTIVE, 5 V_FP, 6 V_SYNC, 7 V_BP.
- cfg_data  in  CW  write data.
- cfg_commit  in  1  request to apply staging at the next frame end.
- cfg_pending  out  1  commit requested but not yet applied.
- hsync / vsync  out  1  sync outputs, polarity set by HS_POL / VS_POL.
- de  out  1  active-video enable.
- x_pos / y_pos  out  CW  relative coordinates within the active area; 0 outside it.
- line_start  out  1  one-cycle strobe on h=0 of every line.
- frame_start  out  1  one-cycle strobe on h=0, v=0.

## Operation
- Counters h, v are 0-based. HT = H_SYNC+H_BP+H_ACTIVE+H_FP and VT = V_SYNC+V_BP+V_ACTIVE+V_FP are registered from the active config whenever that config loads.
- Line order is sync, back porch, active, front porch:
  - hsync is asserted for h < H_SYNC.
  - hde = H_SYNC+H_BP ≤ h < H_SYNC+H_BP+H_ACTIVE.
  - The vertical axis uses the same structure on v.
- de = hde & vde. x_pos = h−(H_SYNC+H_BP) when de, else 0. y_pos = v−(V_SYNC+V_BP) when vde, else 0.
- Counter advance, when en=1:
  - h wraps to 0 at HT−1.
  - v increments on that wrap and wraps to 0 at VT−1 together with h.
  - When en=0, h and v hold. Outputs are recomputed from the held values, except de, line_start and frame_start, which are forced to 0.
- Configuration:
  - cfg_we writes staging[cfg_addr] on any cycle.
  - cfg_commit sets pending.
  - At the frame-end cycle (en=1, h=HT−1, v=VT−1) with pending already set, the active config takes staging and pending clears. This takes effect at the next frame start.
  - A commit on the frame-end cycle itself is deferred one full frame.
  - A cfg_we on the load cycle does not reach the active config on that load.
- Zero-valued or overflowing config values are illegal. They are not checked; the result is undefined but must not lock up beyond the next reset.

## Timing
- All outputs are registered. The outputs after edge n reflect the counter value held before edge n, giving a 1-cycle latency from counter to pins.
- Reset values:
  - h=v=0.
  - Active and staging config = parameters. pending=0.
  - hsync=~HS_POL, vsync=~VS_POL.
  - de=0, x_pos=y_pos=0, line_start=frame_start=0.
- First edge after reset release with en=1: outputs decode h=0, v=0. frame_start=1, line_start=1, hsync and vsync asserted.
- Reset mid-frame returns everything to the reset values immediately and asynchronously. The staging contents are lost.

## Test plan
- Reset then run with defaults:
  - frame_start high after edge 1.
  - frame_start period 2,475,000 cycles; line_start period 2200.
  - hsync asserted 44 cycles per line; vsync asserted 5×2200 cycles.
- Active window at defaults:
  - de first high at the output of h=192, v=41.
  - de high for 1920 consecutive cycles per line, 1080 lines, 2,073,600 cycles per frame.
  - x_pos runs 0..1919 and y_pos runs 0..1079 during de.
- Mid-frame reconfig to 720p (1280,110,40,220 / 720,5,5,20) plus commit:
  - cfg_pending=1 and the current frame finishes at 2200×1125.
  - The next frame has line period 1650 and frame period 1,237,500. pending=0.
- Commit on the exact frame-end cycle: the next frame is still the old timing, and the new timing applies one frame later.
- en low for 100 cycles mid-line:
  - h and v are frozen; de, line_start and frame_start stay 0.
  - On release, the sequence resumes from the held position with no lost count.
- Polarity HS_POL=0, VS_POL=0:
  - Reset gives hsync=vsync=1.
  - Sync pulses go low for 44 cycles and 5 lines.
- Async rst asserted mid-active-line: all outputs return to their reset values without waiting for a clock edge, and the sequence restarts from frame_start.

Source files
------------

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// Raster timing generator: sync/porch/active counters, registered decode, and
// shadowed timing configuration that swaps in only at the end of a frame.
module vga_timing_gen #(
   parameter int   CW       = 12,
   parameter int   H_ACTIVE = 1920,
   parameter int   H_FP     = 88,
   parameter int   H_SYNC   = 44,
   parameter int   H_BP     = 148,
   parameter int   V_ACTIVE = 1080,
   parameter int   V_FP     = 4,
   parameter int   V_SYNC   = 5,
   parameter int   V_BP     = 36,
   parameter logic HS_POL   = 1'b1,
   parameter logic VS_POL   = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          cfg_we,
   input  logic [2:0]    cfg_addr,
   input  logic [CW-1:0] cfg_data,
   input  logic          cfg_commit,
   output logic          cfg_pending,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic [CW-1:0] x_pos,
   output logic [CW-1:0] y_pos,
   output logic          line_start,
   output logic          frame_start
);

   localparam logic [CW-1:0] RST_HS_END  = CW'(H_SYNC);
   localparam logic [CW-1:0] RST_HDE_BEG = CW'(H_SYNC + H_BP);
   localparam logic [CW-1:0] RST_HDE_END = CW'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [CW-1:0] RST_H_LAST  = CW'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
   localparam logic [CW-1:0] RST_VS_END  = CW'(V_SYNC);
   localparam logic [CW-1:0] RST_VDE_BEG = CW'(V_SYNC + V_BP);
   localparam logic [CW-1:0] RST_VDE_END = CW'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [CW-1:0] RST_V_LAST  = CW'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);

   function automatic logic [CW-1:0] f_rst_cfg(input logic [2:0] a);
      logic [CW-1:0] v;
      case (a)
         3'd0:    v = CW'(H_ACTIVE);
         3'd1:    v = CW'(H_FP);
         3'd2:    v = CW'(H_SYNC);
         3'd3:    v = CW'(H_BP);
         3'd4:    v = CW'(V_ACTIVE);
         3'd5:    v = CW'(V_FP);
         3'd6:    v = CW'(V_SYNC);
         default: v = CW'(V_BP);
      endcase
      return v;
   endfunction

   logic [CW-1:0] r_stg [8];
   logic          r_pending;
   logic [CW-1:0] r_h;
   logic [CW-1:0] r_v;

   // Active timing is held as decode boundaries rather than raw field values.
   logic [CW-1:0] r_hs_end, r_hde_beg, r_hde_end, r_h_last;
   logic [CW-1:0] r_vs_end, r_vde_beg, r_vde_end, r_v_last;

   logic [CW-1:0] w_stg_hde_beg, w_stg_hde_end, w_stg_h_last;
   logic [CW-1:0] w_stg_vde_beg, w_stg_vde_end, w_stg_v_last;
   logic          w_h_wrap, w_v_wrap, w_frame_end, w_load;
   logic          w_hde, w_vde, w_de;

   always_comb begin
      w_stg_hde_beg = r_stg[2] + r_stg[3];
      w_stg_hde_end = w_stg_hde_beg + r_stg[0];
      w_stg_h_last  = w_stg_hde_end + r_stg[1] - 1'b1;
      w_stg_vde_beg = r_stg[6] + r_stg[7];
      w_stg_vde_end = w_stg_vde_beg + r_stg[4];
      w_stg_v_last  = w_stg_vde_end + r_stg[5] - 1'b1;
   end

   // Wrap on >= so a bad configuration can never run the counters away.
   assign w_h_wrap    = (r_h >= r_h_last);
   assign w_v_wrap    = (r_v >= r_v_last);
   assign w_frame_end = en & w_h_wrap & w_v_wrap;
   assign w_load      = w_frame_end & r_pending;

   assign w_hde = (r_h >= r_hde_beg) && (r_h < r_hde_end);
   assign w_vde = (r_v >= r_vde_beg) && (r_v < r_vde_end);
   assign w_de  = w_hde & w_vde;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_h <= '0;
         r_v <= '0;
      end else if (en) begin
         if (w_h_wrap) begin
            r_h <= '0;
            r_v <= w_v_wrap ? '0 : r_v + 1'b1;
         end else begin
            r_h <= r_h + 1'b1;
         end
      end
   end

   // A commit landing on the load cycle itself re-arms pending for the next frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending <= 1'b0;
         for (int i = 0; i < 8; i++) r_stg[i] <= f_rst_cfg(3'(i));
      end else begin
         r_pending <= (r_pending & ~w_load) | cfg_commit;
         if (cfg_we) r_stg[cfg_addr] <= cfg_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hs_end  <= RST_HS_END;
         r_hde_beg <= RST_HDE_BEG;
         r_hde_end <= RST_HDE_END;
         r_h_last  <= RST_H_LAST;
         r_vs_end  <= RST_VS_END;
         r_vde_beg <= RST_VDE_BEG;
         r_vde_end <= RST_VDE_END;
         r_v_last  <= RST_V_LAST;
      end else if (w_load) begin
         r_hs_end  <= r_stg[2];
         r_hde_beg <= w_stg_hde_beg;
         r_hde_end <= w_stg_hde_end;
         r_h_last  <= w_stg_h_last;
         r_vs_end  <= r_stg[6];
         r_vde_beg <= w_stg_vde_beg;
         r_vde_end <= w_stg_vde_end;
         r_v_last  <= w_stg_v_last;
      end
   end

   // Outputs decode the counter value present before the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         de          <= 1'b0;
         x_pos       <= '0;
         y_pos       <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         hsync       <= (r_h < r_hs_end) ? HS_POL : ~HS_POL;
         vsync       <= (r_v < r_vs_end) ? VS_POL : ~VS_POL;
         de          <= en & w_de;
         x_pos       <= w_de ? (r_h - r_hde_beg) : '0;
         y_pos       <= w_vde ? (r_v - r_vde_beg) : '0;
         line_start  <= en & (r_h == '0);
         frame_start <= en & (r_h == '0) & (r_v == '0);
      end
   end

   assign cfg_pending = r_pending;

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Bench for vga_timing_gen using small raster modes; a cycle model feeds an
// expected-output queue and period/width statistics are checked per frame.
module tb_vga_timing_gen;
  localparam int CW = 8;
  localparam int HA = 16, HF = 4, HS = 3, HB = 5;
  localparam int VA = 6, VF = 2, VS = 2, VB = 3;
  localparam int W = 5 + 2 * CW;

  logic clk = 1'b0;
  logic rst, en, cfg_we, cfg_commit;
  logic [2:0] cfg_addr;
  logic [CW-1:0] cfg_data;
  logic cfg_pending, hsync, vsync, de, line_start, frame_start;
  logic [CW-1:0] x_pos, y_pos;
  logic pend_n, hsync_n, vsync_n, de_n, ls_n, fs_n;
  logic [CW-1:0] x_n, y_n;

  vga_timing_gen #(.CW(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .HS_POL(1'b1), .VS_POL(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_pending(cfg_pending), .hsync(hsync), .vsync(vsync), .de(de),
    .x_pos(x_pos), .y_pos(y_pos), .line_start(line_start), .frame_start(frame_start));

  vga_timing_gen #(.CW(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .HS_POL(1'b0), .VS_POL(1'b0)) dut_n (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_pending(pend_n), .hsync(hsync_n), .vsync(vsync_n), .de(de_n),
    .x_pos(x_n), .y_pos(y_n), .line_start(ls_n), .frame_start(fs_n));

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0;
  logic [W-1:0] exp_q[$];

  int m_h, m_v, m_pend;
  int m_act[8], m_stg[8];

  int cyc, last_fs, fs_period, last_ls, ls_period;
  int de_acc, de_frame, hs_acc, hs_line, vs_acc, vs_frame;
  int xmax_acc, xmax_frame, ymax_acc, ymax_frame, def_acc, def_frame;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int cfg_default(input int a);
    case (a)
      0: return HA; 1: return HF; 2: return HS; 3: return HB;
      4: return VA; 5: return VF; 6: return VS; default: return VB;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_act[i] = cfg_default(i);
      m_stg[i] = cfg_default(i);
    end
    m_h = 0; m_v = 0; m_pend = 0;
  endtask

  function automatic int m_ht();
    return m_act[0] + m_act[1] + m_act[2] + m_act[3];
  endfunction

  function automatic int m_vt();
    return m_act[4] + m_act[5] + m_act[6] + m_act[7];
  endfunction

  function automatic logic [W-1:0] model_out();
    int hb, he, vb, ve;
    logic hde, vde, o_hs, o_vs, o_de, o_ls, o_fs;
    logic [CW-1:0] o_x, o_y;
    hb = m_act[2] + m_act[3]; he = hb + m_act[0];
    vb = m_act[6] + m_act[7]; ve = vb + m_act[4];
    hde = (m_h >= hb) && (m_h < he);
    vde = (m_v >= vb) && (m_v < ve);
    o_hs = (m_h < m_act[2]);
    o_vs = (m_v < m_act[6]);
    o_de = en && hde && vde;
    o_x = (hde && vde) ? CW'(m_h - hb) : '0;
    o_y = vde ? CW'(m_v - vb) : '0;
    o_ls = en && (m_h == 0);
    o_fs = en && (m_h == 0) && (m_v == 0);
    return {o_hs, o_vs, o_de, o_x, o_y, o_ls, o_fs};
  endfunction

  task automatic model_step();
    int ht, vt;
    ht = m_ht(); vt = m_vt();
    if (en) begin
      if (m_h == ht - 1 && m_v == vt - 1 && m_pend != 0) begin
        for (int i = 0; i < 8; i++) m_act[i] = m_stg[i];
        m_pend = 0;
      end
      if (m_h == ht - 1) begin
        m_h = 0;
        m_v = (m_v == vt - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end
    if (cfg_commit) m_pend = 1;
    if (cfg_we) m_stg[cfg_addr] = int'(cfg_data);
  endtask

  task automatic clear_stats();
    cyc = 0; last_fs = 0; fs_period = 0; last_ls = 0; ls_period = 0;
    de_acc = 0; de_frame = 0; hs_acc = 0; hs_line = 0; vs_acc = 0; vs_frame = 0;
    xmax_acc = 0; xmax_frame = 0; ymax_acc = 0; ymax_frame = 0; def_acc = -1; def_frame = -1;
  endtask

  // driver + scoreboard: one pixel clock
  task automatic cycle();
    logic [W-1:0] e, obs;
    logic [1:0] pol_exp;
    exp_q.push_back(model_out());
    @(posedge clk);
    model_step();
    #1;
    obs = {hsync, vsync, de, x_pos, y_pos, line_start, frame_start};
    e = exp_q.pop_front();
    check("out", obs, e);
    check("pend", cfg_pending, m_pend);
    pol_exp = ~e[W-1 -: 2];
    check("pol", {hsync_n, vsync_n}, pol_exp);
    cyc++;
    if (frame_start) begin
      fs_period = cyc - last_fs; last_fs = cyc;
      de_frame = de_acc; de_acc = 0; vs_frame = vs_acc; vs_acc = 0;
      xmax_frame = xmax_acc; xmax_acc = 0; ymax_frame = ymax_acc; ymax_acc = 0;
      def_frame = def_acc; def_acc = -1;
    end
    if (line_start) begin
      ls_period = cyc - last_ls; last_ls = cyc;
      hs_line = hs_acc; hs_acc = 0;
    end
    if (hsync) hs_acc++;
    if (vsync) vs_acc++;
    if (de) begin
      de_acc++;
      if (int'(x_pos) > xmax_acc) xmax_acc = int'(x_pos);
      if (int'(y_pos) > ymax_acc) ymax_acc = int'(y_pos);
      if (def_acc < 0) def_acc = cyc - last_fs;
    end
  endtask

  task automatic wait_fs();
    int g = 0;
    do begin
      cycle(); g++;
    end while (frame_start !== 1'b1 && g < 3000);
    check("fs_timeout", (g < 3000), 1);
  endtask

  task automatic cfg_write(input int a, input int d);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_data = CW'(d);
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic check_mode(input string tag, input int ht, input int vt, input int ha,
                            input int va, input int hs, input int vs, input int def);
    check({tag, "_frame_period"}, fs_period, ht * vt);
    check({tag, "_line_period"}, ls_period, ht);
    check({tag, "_de_count"}, de_frame, ha * va);
    check({tag, "_hs_width"}, hs_line, hs);
    check({tag, "_vs_width"}, vs_frame, vs * ht);
    check({tag, "_x_max"}, xmax_frame, ha - 1);
    check({tag, "_y_max"}, ymax_frame, va - 1);
    check({tag, "_de_first"}, def_frame, def);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, frz_bad;
    logic [W-1:0] obs;
    rst = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0; cfg_addr = '0; cfg_data = '0;
    model_reset();
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    obs = {hsync, vsync, de, x_pos, y_pos, line_start, frame_start};
    check("rst_out", obs, 0);
    check("rst_pend", cfg_pending, 0);
    check("rst_pol", {hsync_n, vsync_n}, 2'b11);

    // first edge after release decodes h=0, v=0
    rst = 1'b0; en = 1'b1;
    cycle();
    check("fs_first", frame_start, 1);
    check("ls_first", line_start, 1);
    wait_fs();
    check_mode("dflt", 28, 13, 16, 6, 3, 2, 148);

    // freeze mid-line inside the active area
    g = 0;
    while (!(m_v == 6 && m_h == 10) && g < 1000) begin cycle(); g++; end
    check("frz_pos_timeout", (g < 1000), 1);
    en = 1'b0;
    frz_bad = 0;
    repeat (100) begin
      cycle();
      frz_bad += int'(de) + int'(line_start) + int'(frame_start);
    end
    check("frz_strobes", frz_bad, 0);
    check("frz_x", x_pos, 2);
    check("frz_y", y_pos, 1);
    en = 1'b1;
    wait_fs();
    check("frz_frame_period", fs_period, 364 + 100);

    // mid-frame reconfiguration
    repeat (50) cycle();
    cfg_write(0, 10); cfg_write(1, 2); cfg_write(2, 2); cfg_write(3, 3);
    cfg_write(4, 4);  cfg_write(5, 1); cfg_write(6, 1); cfg_write(7, 2);
    cfg_commit = 1'b1; cycle(); cfg_commit = 1'b0;
    check("pend_set", cfg_pending, 1);
    wait_fs();
    check("old_frame_period", fs_period, 364);
    check("pend_clr", cfg_pending, 0);
    wait_fs();
    check_mode("b", 17, 8, 10, 4, 2, 1, 56);

    // commit exactly on the frame-end cycle is deferred a frame
    cfg_write(0, HA); cfg_write(1, HF); cfg_write(2, HS); cfg_write(3, HB);
    cfg_write(4, VA); cfg_write(5, VF); cfg_write(6, VS); cfg_write(7, VB);
    g = 0;
    while (!(m_h == m_ht() - 1 && m_v == m_vt() - 1) && g < 1000) begin cycle(); g++; end
    check("fe_timeout", (g < 1000), 1);
    cfg_commit = 1'b1; cycle(); cfg_commit = 1'b0;
    check("fe_pend", cfg_pending, 1);
    wait_fs();
    wait_fs();
    check("defer_frame_period", fs_period, 136);
    check("defer_pend_clr", cfg_pending, 0);
    wait_fs();
    check("late_frame_period", fs_period, 364);
    check("late_line_period", ls_period, 28);

    // async reset mid-active-line; staged values must be discarded
    cfg_write(0, 10); cfg_write(4, 4);
    g = 0;
    while (!(m_v == 7 && m_h == 12) && g < 1000) begin cycle(); g++; end
    check("arst_pos_timeout", (g < 1000), 1);
    #3;
    rst = 1'b1;
    #1;
    obs = {hsync, vsync, de, x_pos, y_pos, line_start, frame_start};
    check("arst_out", obs, 0);
    check("arst_pol", {hsync_n, vsync_n}, 2'b11);
    check("arst_pend", cfg_pending, 0);
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
    obs = {hsync, vsync, de, x_pos, y_pos, line_start, frame_start};
    check("rst_hold", obs, 0);
    rst = 1'b0;
    clear_stats();
    cycle();
    check("fs_after_arst", frame_start, 1);
    cfg_commit = 1'b1; cycle(); cfg_commit = 1'b0;
    wait_fs();
    wait_fs();
    check_mode("arst", 28, 13, 16, 6, 3, 2, 148);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
